button_pulser: RTL and testbench

Conditions one raw push-button into a clean single-cycle `pulse` for the alarm-clock control path, directly feeding the display/mode rotation counter's `rotate` input. Inputs pass through a 2-flop synchronizer and a stable-time debouncer. A press-and-hold FSM then emits one pulse per press, plus optional auto-repeat pulses while the button stays held.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/debouncer.sv | 48 ++++
 rtl/button_pulser.sv | 89 ++++++++
 tb/tb_button_pulser.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and default timing for the alarm-clock control path.
// Timing constants assume a 100 MHz clk.
// Button FSM state encoding lives here so every button block agrees on it.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int CLK_HZ             = 100_000_000;
  localparam int DEBOUNCE_CYCLES_DFLT = CLK_HZ / 100;  // 10 ms
  localparam int REPEAT_DELAY_DFLT    = CLK_HZ / 2;    // 500 ms
  localparam int REPEAT_PERIOD_DFLT   = CLK_HZ / 5;    // 200 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Synchronizes one raw button and debounces it by stable time into a clean level.
// Latency: level follows a clean input change 2+DEBOUNCE_CYCLES edges after first sample.
// Backpressure: none; level is a continuous registered signal.
module debouncer
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_TC = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          s;
  logic [DW-1:0] dcnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= btn_in;
      s      <= sync_a;
    end
  end

  // Flip the level only after the input has disagreed with it for the full stable time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      dcnt  <= '0;
    end else if (s == level) begin
      dcnt <= '0;
    end else if (dcnt == DEB_TC) begin
      level <= s;
      dcnt  <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_pulser.sv
// Turns a raw push-button into one pulse per press plus optional auto-repeat pulses.
// Latency: pulse follows edge 3+DEBOUNCE_CYCLES after the first high sample of a clean press.
// Backpressure: none; pulse is a single-cycle strobe the consumer must take as it comes.
module button_pulser
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DFLT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic held
);

  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  // REPEAT_DELAY of 0 never enters DELAY, so its terminal count is a don't-care.
  localparam logic [RW-1:0] DELAY_TC  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] PERIOD_TC = RW'(REPEAT_PERIOD - 1);

  logic          level;
  logic          level_q;
  state_t        state;
  logic [RW-1:0] rcnt;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .level (level)
  );

  // The debounced level is already a flop, so it is exposed directly.
  assign held = level;

  // Press/repeat FSM; release is checked first so it beats a coincident repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rcnt    <= '0;
      pulse   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= 1'b0;
      if (!level) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Only a rising level fires; a long hold with repeat disabled stays quiet here.
            if (!level_q) begin
              pulse <= 1'b1;
              rcnt  <= '0;
              state <= (REPEAT_DELAY > 0) ? DELAY : IDLE;
            end
          end
          DELAY: begin
            if (rcnt == DELAY_TC) begin
              pulse <= 1'b1;
              rcnt  <= '0;
              state <= REPEAT;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (rcnt == PERIOD_TC) begin
              pulse <= 1'b1;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_pulser.sv
// Bench for button_pulser: two instances (auto-repeat on and off) share one button.
// Expected outputs come from a window-based level model and an arithmetic pulse schedule.
// Each test task drives its own stimulus and checks inline.
module tb_button_pulser;
  import clock_pkg::*;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic pulse, held, pulse0, held0;

  int checks = 0;
  int errors = 0;

  button_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .pulse(pulse), .held(held)
  );

  button_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .pulse(pulse0), .held(held0)
  );

  always #5 clk = ~clk;

  // Reference model: k counts edges since reset release; samp[i] is btn_in at edge i,
  // lvlh[i] is the debounced level after edge i.
  int k;
  bit samp[$];
  bit lvlh[$];
  int press;
  bit exp_pulse, exp_pulse0, exp_held;

  function automatic bit rep_due(input int kk, input int pe, input int rd);
    return (rd > 0) && (kk - pe >= rd) && (((kk - pe - rd) % RP) == 0);
  endfunction

  task automatic model_reset();
    k = 0;
    samp.delete(); samp.push_back(1'b0);
    lvlh.delete(); lvlh.push_back(1'b0);
    press = 0;
    exp_pulse = 1'b0; exp_pulse0 = 1'b0; exp_held = 1'b0;
  endtask

  // Drive one sample, advance one edge, update the model, land 1 time unit after the edge.
  task automatic tick(input bit b);
    bit l_now, l_prev, flip;
    btn_in = b;
    @(posedge clk);
    k++;
    samp.push_back(b);
    l_now  = lvlh[k-1];
    l_prev = (k >= 2) ? lvlh[k-2] : 1'b0;
    // Level flips once the synchronized input (two samples late) has disagreed for D edges.
    flip = 1'b1;
    for (int i = k - 1 - D; i <= k - 2; i++)
      if (((i >= 1) ? samp[i] : 1'b0) == l_now) flip = 1'b0;
    lvlh.push_back(flip ? !l_now : l_now);
    exp_held = lvlh[k];
    if (l_now && !l_prev) press = k;
    exp_pulse  = l_now && (!l_prev || rep_due(k, press, RD));
    exp_pulse0 = l_now && !l_prev;
    #1;
  endtask

  task automatic test_reset();
    btn_in = 1'b1;
    #2;
    checks++;
    if ({pulse, held, pulse0, held0} !== 4'b0000) begin
      errors++; $display("FAIL reset_initial got=%b required=0000", {pulse, held, pulse0, held0});
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({pulse, held, pulse0, held0} !== 4'b0000) begin
      errors++; $display("FAIL reset_held_btn got=%b required=0000", {pulse, held, pulse0, held0});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_press();
    int first_held = -1, last_held = -1, npulse = 0, pedge = -1;
    for (int i = 0; i < 20; i++) begin
      tick(i < 8);
      checks++;
      if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
        errors++; $display("FAIL clean_cycle k=%0d got=%b required=%b", k,
          {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
      end
      if (held && first_held < 0) first_held = k;
      if (held) last_held = k;
      if (pulse) begin npulse++; pedge = k; end
    end
    checks++;
    if (first_held !== 6) begin errors++; $display("FAIL clean_held_rise got=%0d required=6", first_held); end
    checks++;
    if (npulse !== 1 || pedge !== 7) begin
      errors++; $display("FAIL clean_pulse got count=%0d edge=%0d required count=1 edge=7", npulse, pedge);
    end
    checks++;
    if (last_held !== 13) begin errors++; $display("FAIL clean_held_fall got=%0d required=13", last_held); end
  endtask

  task automatic test_bounce();
    int t = 0, w, s_edge, npulse = 0, pedge = -1;
    for (int i = 0; i < 8; i++) tick(1'b0);
    while (t < 20) begin
      w = $urandom_range(1, 3);
      for (int i = 0; i < w; i++) begin
        tick(1'b1);
        checks++;
        if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
          errors++; $display("FAIL bounce_cycle k=%0d got=%b required=%b", k,
            {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
        end
        if (pulse) begin npulse++; pedge = k; end
      end
      w = $urandom_range(1, 3);
      for (int i = 0; i < w; i++) begin
        tick(1'b0);
        if (pulse) begin npulse++; pedge = k; end
      end
      t += 2 * w;
    end
    s_edge = k + 1;
    for (int i = 0; i < 20; i++) begin
      tick(i < 9);
      checks++;
      if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
        errors++; $display("FAIL bounce_cycle k=%0d got=%b required=%b", k,
          {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
      end
      if (pulse) begin npulse++; pedge = k; end
    end
    checks++;
    if (npulse !== 1 || pedge !== s_edge + 6) begin
      errors++; $display("FAIL bounce_single got count=%0d edge=%0d required count=1 edge=%0d",
        npulse, pedge, s_edge + 6);
    end
  endtask

  task automatic test_auto_repeat();
    int s_edge, e, got[$], want[$];
    for (int i = 0; i < 8; i++) tick(1'b0);
    s_edge = k + 1;
    for (int i = 0; i < 55; i++) begin
      tick(i < 40);
      checks++;
      if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
        errors++; $display("FAIL repeat_cycle k=%0d got=%b required=%b", k,
          {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
      end
      if (pulse) got.push_back(k);
    end
    // Level falls after edge s+40+D+1; the FSM needs it high on the edge before a pulse.
    want.push_back(s_edge + 6);
    for (e = s_edge + 6 + RD; e <= s_edge + 40 + D + 1; e += RP) want.push_back(e);
    checks++;
    if (got.size() !== want.size()) begin
      errors++; $display("FAIL repeat_count got=%0d required=%0d", got.size(), want.size());
    end else begin
      foreach (want[i]) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++; $display("FAIL repeat_edge[%0d] got=%0d required=%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_repeat_disabled();
    int npulse0 = 0;
    for (int i = 0; i < 8; i++) tick(1'b0);
    for (int i = 0; i < 55; i++) begin
      tick(i < 40);
      checks++;
      if ({pulse0, held0} !== {exp_pulse0, exp_held}) begin
        errors++; $display("FAIL norepeat_cycle k=%0d got=%b required=%b", k,
          {pulse0, held0}, {exp_pulse0, exp_held});
      end
      if (pulse0) npulse0++;
    end
    checks++;
    if (npulse0 !== 1) begin errors++; $display("FAIL norepeat_count got=%0d required=1", npulse0); end
  endtask

  task automatic test_reset_mid_hold();
    int s_edge, n_edge, e, got[$], want[$];
    for (int i = 0; i < 8; i++) tick(1'b0);
    s_edge = k + 1;
    n_edge = s_edge + 6;
    while (k < n_edge + 12) begin
      tick(1'b1);
      checks++;
      if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
        errors++; $display("FAIL midreset_cycle k=%0d got=%b required=%b", k,
          {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pulse, held, pulse0, held0} !== 4'b0000) begin
      errors++; $display("FAIL midreset_async got=%b required=0000", {pulse, held, pulse0, held0});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      tick(i < 25);
      checks++;
      if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
        errors++; $display("FAIL midreset_cycle k=%0d got=%b required=%b", k,
          {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
      end
      if (pulse) got.push_back(k);
    end
    want.push_back(7);
    for (e = 7 + RD; e <= 25 + D + 2; e += RP) want.push_back(e);
    checks++;
    if (got.size() !== want.size() || got[0] !== 7) begin
      errors++; $display("FAIL midreset_restart got count=%0d first=%0d required count=%0d first=7",
        got.size(), (got.size() > 0) ? got[0] : -1, want.size());
    end
  endtask

  task automatic test_release_on_tc();
    int s_edge, n_edge;
    for (int i = 0; i < 8; i++) tick(1'b0);
    s_edge = k + 1;
    n_edge = s_edge + 6;
    for (int i = 0; i < 24; i++) begin
      tick(i < 10);
      checks++;
      if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
        errors++; $display("FAIL tc_cycle k=%0d got=%b required=%b", k,
          {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
      end
      if (k == n_edge + 9) begin
        checks++;
        if (held !== 1'b0 || dut.rcnt !== RD - 1) begin
          errors++; $display("FAIL tc_coincide got held=%b rcnt=%0d required held=0 rcnt=%0d",
            held, dut.rcnt, RD - 1);
        end
      end
      if (k == n_edge + 10) begin
        checks++;
        if (pulse !== 1'b0 || dut.state !== IDLE || dut.rcnt !== 0) begin
          errors++; $display("FAIL tc_release got pulse=%b state=%0d rcnt=%0d required 0/IDLE/0",
            pulse, dut.state, dut.rcnt);
        end
      end
    end
  endtask

  task automatic test_random();
    bit b = 1'b0;
    int w;
    for (int seg = 0; seg < 40; seg++) begin
      w = $urandom_range(1, 14);
      b = ~b;
      for (int i = 0; i < w; i++) begin
        tick(b);
        checks++;
        if ({pulse, held, pulse0, held0} !== {exp_pulse, exp_held, exp_pulse0, exp_held}) begin
          errors++; $display("FAIL random_cycle k=%0d got=%b required=%b", k,
            {pulse, held, pulse0, held0}, {exp_pulse, exp_held, exp_pulse0, exp_held});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_disabled();
    test_reset_mid_hold();
    test_release_on_tc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
